cache_l2_burst_control: RTL and testbench

Control FSM for a parametrised N-way set-associative L2 cache whose line is moved to and from physical memory as a multi-beat burst. It sits between the L2 datapath (tag/valid/dirty/LRU arrays, line data array) and physical memory. It selects a victim way (first invalid, else LRU), sequences dirty write-back and refill beat by beat, and keeps saturating hit/miss performance counters.

---
 rtl/cache_l2_burst_control.sv | 206 ++++++++++++++++++++
 tb/tb_cache_l2_burst_control.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_l2_burst_control.sv
// Control FSM for an N-way set-associative L2 cache with multi-beat line
// bursts to physical memory. Picks a victim way (first invalid, else LRU),
// sequences dirty write-back and refill one beat at a time, and keeps
// saturating hit/miss performance counters.
//
// Handshake: mem_read/mem_write are level requests held by the CPU side until
// mem_resp is seen high at a rising clk edge; pmem_read/pmem_write stay high
// for the whole burst and each cycle with pmem_resp high transfers exactly one
// beat (beat_idx); the strobe drops the cycle after the final-beat response.
module cache_l2_burst_control #(
  parameter int NUM_WAYS = 4,
  parameter int BEATS    = 4,
  parameter int CNT_W    = 32,
  localparam int WAY_W   = $clog2(NUM_WAYS),
  localparam int BEAT_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-1:0] dirty_vec,
  input  logic [WAY_W-1:0]  lru_way,
  input  logic              pmem_resp,
  output logic              mem_resp,
  output logic [WAY_W-1:0]  way_sel,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              cpu_we,
  output logic              line_we,
  output logic              tag_we,
  output logic              valid_set,
  output logic              dirty_set,
  output logic              dirty_clr,
  output logic              lru_update,
  output logic              load_addr,
  output logic              pmarmux_sel,
  output logic              datamux_sel,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_LOOKUP     = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_FILL       = 2'd2
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WAY_W-1:0]  victim_q;
  logic              refill_q;

  logic              req;
  logic              is_write;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim;
  logic              victim_dirty;
  logic              last_beat;
  logic              hit_sat;
  logic              miss_sat;

  assign req       = mem_read | mem_write;
  // A simultaneous read and write is handled as a write.
  assign is_write  = mem_write;
  assign hit_any   = |hit_vec;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign hit_sat   = (hit_count == {CNT_W{1'b1}});
  assign miss_sat  = (miss_count == {CNT_W{1'b1}});
  assign state_dbg = state;

  // Lowest-index hit way and lowest-index invalid way (scan high to low so
  // the lowest index wins); fall back to the LRU way when the set is full.
  always_comb begin
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
      if (!valid_vec[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
    victim       = inv_found ? inv_way : lru_way;
    victim_dirty = valid_vec[victim] & dirty_vec[victim];
  end

  // Datapath strobes, decoded from the current state and inputs.
  always_comb begin
    mem_resp    = 1'b0;
    way_sel     = '0;
    beat_idx    = beat_cnt;
    cpu_we      = 1'b0;
    line_we     = 1'b0;
    tag_we      = 1'b0;
    valid_set   = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    lru_update  = 1'b0;
    load_addr   = 1'b0;
    pmarmux_sel = 1'b0;
    datamux_sel = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    case (state)
      S_LOOKUP: begin
        if (req) begin
          if (hit_any) begin
            mem_resp    = 1'b1;
            way_sel     = hit_way;
            lru_update  = 1'b1;
            datamux_sel = 1'b1;
            if (is_write) begin
              cpu_we    = 1'b1;
              dirty_set = 1'b1;
            end
          end else begin
            way_sel     = victim;
            load_addr   = 1'b1;
            pmarmux_sel = victim_dirty;
          end
        end
      end
      S_WRITE_BACK: begin
        pmem_write  = 1'b1;
        way_sel     = victim_q;
        pmarmux_sel = 1'b1;
        if (pmem_resp && last_beat) begin
          // Swap the pmem address over to the CPU line for the refill.
          load_addr   = 1'b1;
          pmarmux_sel = 1'b0;
          dirty_clr   = 1'b1;
        end
      end
      S_FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          line_we = 1'b1;
          if (last_beat) begin
            tag_we    = 1'b1;
            valid_set = 1'b1;
            dirty_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State, beat counter, victim latch, refill flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOOKUP;
      beat_cnt   <= '0;
      victim_q   <= '0;
      refill_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        S_LOOKUP: begin
          if (req) begin
            if (hit_any) begin
              // The completing re-lookup after a refill is not a real hit.
              refill_q <= 1'b0;
              if (!refill_q && !hit_sat) hit_count <= hit_count + CNT_W'(1);
            end else begin
              victim_q <= victim;
              beat_cnt <= '0;
              state    <= victim_dirty ? S_WRITE_BACK : S_FILL;
              if (!refill_q && !miss_sat) miss_count <= miss_count + CNT_W'(1);
            end
          end else begin
            refill_q <= 1'b0;
          end
        end
        S_WRITE_BACK: begin
          if (pmem_resp) begin
            // BEATS is a power of two, so the increment wraps to 0 after the last beat.
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) state <= S_FILL;
          end
        end
        S_FILL: begin
          if (pmem_resp) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) begin
              refill_q <= 1'b1;
              state    <= S_LOOKUP;
            end
          end
        end
        default: state <= S_LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_l2_burst_control.sv
// Directed bench for cache_l2_burst_control: hits, clean and dirty misses,
// request drop mid-refill, reset mid-burst and counter saturation. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_cache_l2_burst_control;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] hit_vec;
  logic [3:0] valid_vec;
  logic [3:0] dirty_vec;
  logic [1:0] lru_way;
  logic       pmem_resp;

  logic        mem_resp, cpu_we, line_we, tag_we, valid_set, dirty_set, dirty_clr;
  logic        lru_update, load_addr, pmarmux_sel, datamux_sel, pmem_read, pmem_write;
  logic [1:0]  way_sel, beat_idx, state_dbg;
  logic [31:0] hit_count, miss_count;

  logic        s_mem_resp, s_cpu_we, s_line_we, s_tag_we, s_valid_set, s_dirty_set, s_dirty_clr;
  logic        s_lru_update, s_load_addr, s_pmarmux_sel, s_datamux_sel, s_pmem_read, s_pmem_write;
  logic [1:0]  s_way_sel, s_beat_idx, s_state_dbg;
  logic [1:0]  s_hit_count, s_miss_count;

  int checks;
  int failures;
  int exp_hits;
  int exp_misses;

  localparam logic [1:0] ST_LOOKUP = 2'd0;
  localparam logic [1:0] ST_WB     = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;

  cache_l2_burst_control #(.NUM_WAYS(4), .BEATS(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp), .way_sel(way_sel), .beat_idx(beat_idx),
    .cpu_we(cpu_we), .line_we(line_we), .tag_we(tag_we), .valid_set(valid_set),
    .dirty_set(dirty_set), .dirty_clr(dirty_clr), .lru_update(lru_update),
    .load_addr(load_addr), .pmarmux_sel(pmarmux_sel), .datamux_sel(datamux_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .hit_count(hit_count),
    .miss_count(miss_count), .state_dbg(state_dbg)
  );

  cache_l2_burst_control #(.NUM_WAYS(4), .BEATS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way),
    .pmem_resp(pmem_resp), .mem_resp(s_mem_resp), .way_sel(s_way_sel), .beat_idx(s_beat_idx),
    .cpu_we(s_cpu_we), .line_we(s_line_we), .tag_we(s_tag_we), .valid_set(s_valid_set),
    .dirty_set(s_dirty_set), .dirty_clr(s_dirty_clr), .lru_update(s_lru_update),
    .load_addr(s_load_addr), .pmarmux_sel(s_pmarmux_sel), .datamux_sel(s_datamux_sel),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .hit_count(s_hit_count),
    .miss_count(s_miss_count), .state_dbg(s_state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change on the falling edge; one call advances one rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit_vec   = 4'b0000;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    valid_vec = 4'b1111;
    dirty_vec = 4'b0000;
    lru_way   = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_LOOKUP) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_LOOKUP); end
    checks++; if (hit_count !== 32'd0) begin failures++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
    checks++; if (beat_idx !== 2'd0) begin failures++; $display("FAIL reset_beat_idx got=%0d exp=0", beat_idx); end
    checks++; if ({mem_resp, pmem_read, pmem_write, load_addr} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {mem_resp, pmem_read, pmem_write, load_addr}); end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic test_read_hit();
    mem_read = 1'b1;
    hit_vec  = 4'b0100;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL rd_hit_resp got=%0d exp=1", mem_resp); end
    checks++; if (way_sel !== 2'd2) begin failures++; $display("FAIL rd_hit_way got=%0d exp=2", way_sel); end
    checks++; if (lru_update !== 1'b1) begin failures++; $display("FAIL rd_hit_lru got=%0d exp=1", lru_update); end
    checks++; if (cpu_we !== 1'b0) begin failures++; $display("FAIL rd_hit_cpu_we got=%0d exp=0", cpu_we); end
    checks++; if (datamux_sel !== 1'b1) begin failures++; $display("FAIL rd_hit_datamux got=%0d exp=1", datamux_sel); end
    tick();
    set_idle();
    exp_hits++;
    checks++; if (hit_count !== 32'(exp_hits)) begin failures++; $display("FAIL rd_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
  endtask

  task automatic test_write_hit();
    mem_write = 1'b1;
    hit_vec   = 4'b0001;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL wr_hit_resp got=%0d exp=1", mem_resp); end
    checks++; if (cpu_we !== 1'b1) begin failures++; $display("FAIL wr_hit_cpu_we got=%0d exp=1", cpu_we); end
    checks++; if (dirty_set !== 1'b1) begin failures++; $display("FAIL wr_hit_dirty_set got=%0d exp=1", dirty_set); end
    checks++; if (way_sel !== 2'd0) begin failures++; $display("FAIL wr_hit_way got=%0d exp=0", way_sel); end
    checks++; if (datamux_sel !== 1'b1) begin failures++; $display("FAIL wr_hit_datamux got=%0d exp=1", datamux_sel); end
    tick();
    exp_hits++;
    // Read and write together behave as a write.
    mem_read  = 1'b1;
    mem_write = 1'b1;
    hit_vec   = 4'b1000;
    #1;
    checks++; if (cpu_we !== 1'b1) begin failures++; $display("FAIL rdwr_cpu_we got=%0d exp=1", cpu_we); end
    checks++; if (way_sel !== 2'd3) begin failures++; $display("FAIL rdwr_way got=%0d exp=3", way_sel); end
    tick();
    exp_hits++;
    // Multi-hot hit vector resolves to the lowest index.
    mem_write = 1'b0;
    hit_vec   = 4'b0110;
    #1;
    checks++; if (way_sel !== 2'd1) begin failures++; $display("FAIL multihot_way got=%0d exp=1", way_sel); end
    checks++; if (dirty_set !== 1'b0) begin failures++; $display("FAIL multihot_dirty_set got=%0d exp=0", dirty_set); end
    tick();
    exp_hits++;
    set_idle();
    checks++; if (hit_count !== 32'(exp_hits)) begin failures++; $display("FAIL wr_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
  endtask

  task automatic test_clean_miss();
    mem_read  = 1'b1;
    hit_vec   = 4'b0000;
    valid_vec = 4'b1011;
    dirty_vec = 4'b1111;
    lru_way   = 2'd0;
    #1;
    checks++; if (load_addr !== 1'b1) begin failures++; $display("FAIL cmiss_load_addr got=%0d exp=1", load_addr); end
    checks++; if (pmarmux_sel !== 1'b0) begin failures++; $display("FAIL cmiss_pmarmux got=%0d exp=0", pmarmux_sel); end
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL cmiss_resp got=%0d exp=0", mem_resp); end
    tick();
    exp_misses++;
    #1;
    checks++; if (state_dbg !== ST_FILL) begin failures++; $display("FAIL cmiss_state got=%0d exp=%0d", state_dbg, ST_FILL); end
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL cmiss_pmem_read got=%0d exp=1", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL cmiss_pmem_write got=%0d exp=0", pmem_write); end
    checks++; if (way_sel !== 2'd2) begin failures++; $display("FAIL cmiss_way got=%0d exp=2", way_sel); end
    checks++; if (line_we !== 1'b0) begin failures++; $display("FAIL cmiss_line_we_wait got=%0d exp=0", line_we); end
    tick();
    for (int b = 0; b < 4; b++) begin
      pmem_resp = 1'b1;
      #1;
      checks++; if (beat_idx !== b[1:0]) begin failures++; $display("FAIL cmiss_beat_idx got=%0d exp=%0d", beat_idx, b); end
      checks++; if (line_we !== 1'b1) begin failures++; $display("FAIL cmiss_line_we got=%0d exp=1 beat=%0d", line_we, b); end
      checks++; if (tag_we !== (b == 3)) begin failures++; $display("FAIL cmiss_tag_we got=%0d exp=%0d beat=%0d", tag_we, (b == 3), b); end
      checks++; if (valid_set !== (b == 3)) begin failures++; $display("FAIL cmiss_valid_set got=%0d exp=%0d beat=%0d", valid_set, (b == 3), b); end
      tick();
    end
    pmem_resp = 1'b0;
    hit_vec   = 4'b0100;
    #1;
    checks++; if (state_dbg !== ST_LOOKUP) begin failures++; $display("FAIL cmiss_relookup_state got=%0d exp=%0d", state_dbg, ST_LOOKUP); end
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL cmiss_relookup_resp got=%0d exp=1", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL cmiss_pmem_read_drop got=%0d exp=0", pmem_read); end
    tick();
    set_idle();
    checks++; if (miss_count !== 32'(exp_misses)) begin failures++; $display("FAIL cmiss_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
    checks++; if (hit_count !== 32'(exp_hits)) begin failures++; $display("FAIL cmiss_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
  endtask

  task automatic test_dirty_miss();
    mem_read  = 1'b1;
    hit_vec   = 4'b0000;
    valid_vec = 4'b1111;
    dirty_vec = 4'b0010;
    lru_way   = 2'd1;
    #1;
    checks++; if (load_addr !== 1'b1) begin failures++; $display("FAIL dmiss_load_addr got=%0d exp=1", load_addr); end
    checks++; if (pmarmux_sel !== 1'b1) begin failures++; $display("FAIL dmiss_pmarmux got=%0d exp=1", pmarmux_sel); end
    tick();
    exp_misses++;
    for (int b = 0; b < 4; b++) begin
      pmem_resp = 1'b1;
      #1;
      checks++; if (state_dbg !== ST_WB) begin failures++; $display("FAIL dmiss_wb_state got=%0d exp=%0d", state_dbg, ST_WB); end
      checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL dmiss_pmem_write got=%0d exp=1 beat=%0d", pmem_write, b); end
      checks++; if (way_sel !== 2'd1) begin failures++; $display("FAIL dmiss_wb_way got=%0d exp=1", way_sel); end
      checks++; if (beat_idx !== b[1:0]) begin failures++; $display("FAIL dmiss_wb_beat got=%0d exp=%0d", beat_idx, b); end
      checks++; if (load_addr !== (b == 3)) begin failures++; $display("FAIL dmiss_wb_load_addr got=%0d exp=%0d beat=%0d", load_addr, (b == 3), b); end
      checks++; if (pmarmux_sel !== (b != 3)) begin failures++; $display("FAIL dmiss_wb_pmarmux got=%0d exp=%0d beat=%0d", pmarmux_sel, (b != 3), b); end
      checks++; if (dirty_clr !== (b == 3)) begin failures++; $display("FAIL dmiss_wb_dirty_clr got=%0d exp=%0d beat=%0d", dirty_clr, (b == 3), b); end
      tick();
    end
    pmem_resp = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_FILL) begin failures++; $display("FAIL dmiss_fill_state got=%0d exp=%0d", state_dbg, ST_FILL); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL dmiss_pmem_write_drop got=%0d exp=0", pmem_write); end
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL dmiss_pmem_read got=%0d exp=1", pmem_read); end
    checks++; if (beat_idx !== 2'd0) begin failures++; $display("FAIL dmiss_fill_beat0 got=%0d exp=0", beat_idx); end
    tick();
    for (int b = 0; b < 4; b++) begin
      pmem_resp = 1'b1;
      #1;
      checks++; if (beat_idx !== b[1:0]) begin failures++; $display("FAIL dmiss_fill_beat got=%0d exp=%0d", beat_idx, b); end
      checks++; if (line_we !== 1'b1) begin failures++; $display("FAIL dmiss_fill_line_we got=%0d exp=1 beat=%0d", line_we, b); end
      checks++; if (way_sel !== 2'd1) begin failures++; $display("FAIL dmiss_fill_way got=%0d exp=1", way_sel); end
      tick();
    end
    pmem_resp = 1'b0;
    hit_vec   = 4'b0010;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL dmiss_resp got=%0d exp=1", mem_resp); end
    checks++; if (way_sel !== 2'd1) begin failures++; $display("FAIL dmiss_resp_way got=%0d exp=1", way_sel); end
    tick();
    set_idle();
    checks++; if (miss_count !== 32'(exp_misses)) begin failures++; $display("FAIL dmiss_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
    checks++; if (hit_count !== 32'(exp_hits)) begin failures++; $display("FAIL dmiss_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
    // A stray pmem_resp while idle must not move the FSM or the beat counter.
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_LOOKUP) begin failures++; $display("FAIL idle_resp_state got=%0d exp=%0d", state_dbg, ST_LOOKUP); end
    checks++; if (beat_idx !== 2'd0) begin failures++; $display("FAIL idle_resp_beat got=%0d exp=0", beat_idx); end
  endtask

  task automatic test_drop_request();
    mem_read  = 1'b1;
    hit_vec   = 4'b0000;
    valid_vec = 4'b0111;
    dirty_vec = 4'b1111;
    lru_way   = 2'd0;
    tick();
    exp_misses++;
    for (int b = 0; b < 4; b++) begin
      pmem_resp = 1'b1;
      if (b == 2) mem_read = 1'b0;
      #1;
      checks++; if (way_sel !== 2'd3) begin failures++; $display("FAIL drop_way got=%0d exp=3", way_sel); end
      checks++; if (beat_idx !== b[1:0]) begin failures++; $display("FAIL drop_beat got=%0d exp=%0d", beat_idx, b); end
      checks++; if (line_we !== 1'b1) begin failures++; $display("FAIL drop_line_we got=%0d exp=1 beat=%0d", line_we, b); end
      checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL drop_resp_burst got=%0d exp=0", mem_resp); end
      tick();
    end
    set_idle();
    #1;
    checks++; if (state_dbg !== ST_LOOKUP) begin failures++; $display("FAIL drop_state got=%0d exp=%0d", state_dbg, ST_LOOKUP); end
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL drop_resp_idle got=%0d exp=0", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL drop_pmem_read got=%0d exp=0", pmem_read); end
    tick();
    checks++; if (miss_count !== 32'(exp_misses)) begin failures++; $display("FAIL drop_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
    // The idle cycle cleared the refill flag, so this hit is counted.
    mem_read = 1'b1;
    hit_vec  = 4'b0001;
    #1;
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL drop_next_hit_resp got=%0d exp=1", mem_resp); end
    tick();
    exp_hits++;
    set_idle();
    checks++; if (hit_count !== 32'(exp_hits)) begin failures++; $display("FAIL drop_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
  endtask

  task automatic test_reset_mid_burst();
    // 2-bit counters have seen 5 hits and 3 misses: both pinned at 3.
    checks++; if (s_hit_count !== 2'd3) begin failures++; $display("FAIL sat_hit_pre got=%0d exp=3", s_hit_count); end
    checks++; if (s_miss_count !== 2'd3) begin failures++; $display("FAIL sat_miss_pre got=%0d exp=3", s_miss_count); end
    mem_read  = 1'b1;
    hit_vec   = 4'b0000;
    valid_vec = 4'b1111;
    dirty_vec = 4'b1000;
    lru_way   = 2'd3;
    tick();
    pmem_resp = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (beat_idx !== 2'd2) begin failures++; $display("FAIL rstmid_beat_pre got=%0d exp=2", beat_idx); end
    checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL rstmid_pmem_write_pre got=%0d exp=1", pmem_write); end
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL rstmid_pmem_write got=%0d exp=0", pmem_write); end
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_pmem_read got=%0d exp=0", pmem_read); end
    checks++; if (state_dbg !== ST_LOOKUP) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", state_dbg, ST_LOOKUP); end
    checks++; if (beat_idx !== 2'd0) begin failures++; $display("FAIL rstmid_beat got=%0d exp=0", beat_idx); end
    checks++; if (hit_count !== 32'd0) begin failures++; $display("FAIL rstmid_hit_count got=%0d exp=0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL rstmid_miss_count got=%0d exp=0", miss_count); end
    checks++; if (s_hit_count !== 2'd0) begin failures++; $display("FAIL rstmid_sat_hit got=%0d exp=0", s_hit_count); end
  endtask

  task automatic test_back_to_back();
    // Held request with a hit completes every cycle.
    mem_read = 1'b1;
    hit_vec  = 4'b0001;
    for (int n = 1; n <= 4; n++) begin
      #1;
      checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL b2b_resp got=%0d exp=1 n=%0d", mem_resp, n); end
      tick();
    end
    checks++; if (hit_count !== 32'd4) begin failures++; $display("FAIL b2b_hit_count got=%0d exp=4", hit_count); end
    checks++; if (s_hit_count !== 2'd3) begin failures++; $display("FAIL b2b_sat_hit4 got=%0d exp=3", s_hit_count); end
    tick();
    set_idle();
    checks++; if (hit_count !== 32'd5) begin failures++; $display("FAIL b2b_hit_count5 got=%0d exp=5", hit_count); end
    checks++; if (s_hit_count !== 2'd3) begin failures++; $display("FAIL b2b_sat_hit5 got=%0d exp=3", s_hit_count); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_hits   = 0;
    exp_misses = 0;
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    hit_vec    = 4'b0000;
    valid_vec  = 4'b1111;
    dirty_vec  = 4'b0000;
    lru_way    = 2'd0;
    pmem_resp  = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_drop_request();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
